sram_stream_reader: RTL

Read-side client of the shared 16K×16 packet SRAM, which has 1-cycle read latency. Accepts a read job (start address, word count) and issues `rd_en`/`rd_addr` to the SRAM. Returns the words as a valid/ready stream with a last-word marker. Sits between the dequeue scheduler and the egress port. A credit-limited output FIFO absorbs downstream backpressure without losing in-flight SRAM data.

---
 rtl/sram_stream_reader_pkg.sv | 16 +
 rtl/sram_stream_reader_if.sv | 35 +++
 rtl/sram_stream_reader_fifo.sv | 58 +++++
 rtl/sram_stream_reader.sv | 113 +++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for clients of the 16K x 16 packet SRAM.
// Read-side FSM states and SRAM geometry live here.
package hydra_sram_pkg;

  localparam int SRAM_ADDR_W = 14;
  localparam int SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_e;

endpackage

// File: rtl/sram_stream_reader_if.sv
// Job request, SRAM read port and output stream of the SRAM stream reader.
// The slave modport is the reader's view; master is the surrounding system.
import hydra_sram_pkg::*;

interface sram_stream_reader_if #(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = 10
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  req_valid, req_addr, req_len, rd_data, out_ready,
    output req_ready, rd_en, rd_addr, out_valid, out_data, out_last
  );

  modport master (
    output req_valid, req_addr, req_len, rd_data, out_ready,
    input  req_ready, rd_en, rd_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sram_stream_reader_fifo.sv
// Small first-word-fall-through FIFO holding SRAM words plus their last tag.
// Storage is flop-based and cleared on reset so the head reads zero afterwards.
module sram_rd_fifo
  import hydra_sram_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_W + 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head_data = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= wr_idx + AW'(1);
      end
      if (do_pop) begin
        rd_idx <= rd_idx + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Streams a job of consecutive SRAM words out as a valid/ready stream with a last marker.
// Reads are only issued when the output FIFO has room for every word already in flight.
module sram_stream_reader
  import hydra_sram_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int LEN_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_stream_reader_if.slave   bus,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH);

  rd_state_e         state;
  rd_state_e         next_state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  remain;
  logic              rd_pending;
  logic              last_tag_d;
  logic              idle_ready;
  logic              accept;
  logic              issue;
  logic              pop;
  logic              credit_ok;
  logic [CW:0]       credit_used;
  logic [CW:0]       fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W:0]   head;

  // Words in the FIFO plus the word returning from the SRAM this cycle must fit.
  assign credit_used = fifo_count + {{CW{1'b0}}, rd_pending};
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

  assign accept = idle_ready && bus.req_valid;
  assign pop    = !fifo_empty && bus.out_ready;

  assign bus.req_ready = idle_ready && rst_n;
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = rd_ptr;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head[DATA_W-1:0];
  assign bus.out_last  = head[DATA_W];
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      remain     <= '0;
      rd_pending <= 1'b0;
      last_tag_d <= 1'b0;
    end else begin
      state      <= next_state;
      rd_pending <= issue;
      last_tag_d <= issue && (remain == LEN_W'(1));
      if (accept && (bus.req_len != '0)) begin
        rd_ptr <= bus.req_addr;
        remain <= bus.req_len;
      end else if (issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        remain <= remain - LEN_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    idle_ready = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        idle_ready = 1'b1;
        if (bus.req_valid && (bus.req_len != '0)) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        issue = credit_ok && !fifo_full;
        if (issue && (remain == LEN_W'(1))) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[DATA_W]) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  sram_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pending),
    .push_data ({last_tag_d, bus.rd_data}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
